// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command-frame path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } frame_state_t;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int unsigned BAUD     = 115_200;
  localparam int unsigned BAUD_DIV = 434;

  // Ten byte times (10 bits each) at BAUD_DIV clocks per bit.
  localparam int unsigned TIMEOUT_CLKS_DEF = 43_400;

  function automatic logic len_ok(input logic [7:0] len, input int unsigned max_len);
    return (len != 8'd0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: 2**AW x 8 register file, one synchronous write port, one asynchronous read port.
module uart_frame_buf #(
  parameter int unsigned AW = 4
) (
  input  logic          sys_clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge sys_clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 55 AA | LEN | payload | CHK frames from the UART byte receiver and
// holds a checksum-verified payload for the command decoder until acknowledged.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned AW           = 4,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_valid,
  output logic [AW:0]   frame_len,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam logic [AW:0]  LEN_ONE = 1;
  localparam logic [15:0]  TO_LAST = 16'(TIMEOUT_CLKS - 1);

  frame_state_t state_q, state_d;

  logic          rx_valid_d;
  logic          byte_stb;
  logic [AW:0]   len_q;
  logic [7:0]    sum_q;
  logic [AW-1:0] idx_q;
  logic [15:0]   to_cnt;

  logic in_frame, timeout_hit, len_good, last_byte, chk_match;
  logic buf_we, load_frame;
  logic err_chk_d, err_len_d, err_timeout_d, err_overrun_d;

  always_comb begin
    byte_stb    = rx_valid & ~rx_valid_d;
    in_frame    = (state_q == ST_HDR2) || (state_q == ST_LEN) ||
                  (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    timeout_hit = in_frame && !byte_stb && (to_cnt == TO_LAST);
    len_good    = len_ok(rx_data, MAX_LEN);
    last_byte   = ({1'b0, idx_q} == (len_q - LEN_ONE));
    chk_match   = (rx_data == sum_q);
  end

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (byte_stb && rx_data == HDR0) state_d = ST_HDR2;
      ST_HDR2:    if (byte_stb) begin
                    if (rx_data == HDR1)      state_d = ST_LEN;
                    else if (rx_data != HDR0) state_d = ST_IDLE;
                  end
      ST_LEN:     if (byte_stb) state_d = len_good ? ST_PAYLOAD : ST_IDLE;
      ST_PAYLOAD: if (byte_stb && last_byte) state_d = ST_CHK;
      ST_CHK:     if (byte_stb) state_d = chk_match ? ST_HOLD : ST_IDLE;
      ST_HOLD:    if (frame_ack) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (timeout_hit) state_d = ST_IDLE;
  end

  // Output / datapath-control decode
  always_comb begin
    frame_valid   = (state_q == ST_HOLD);
    buf_we        = (state_q == ST_PAYLOAD) && byte_stb;
    load_frame    = (state_q == ST_CHK) && byte_stb && chk_match;
    err_chk_d     = (state_q == ST_CHK) && byte_stb && !chk_match;
    err_len_d     = (state_q == ST_LEN) && byte_stb && !len_good;
    err_overrun_d = (state_q == ST_HOLD) && byte_stb;
    err_timeout_d = timeout_hit;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_d  <= 1'b1;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      to_cnt      <= '0;
      frame_len   <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_valid_d  <= rx_valid;
      err_chk     <= err_chk_d;
      err_len     <= err_len_d;
      err_timeout <= err_timeout_d;
      err_overrun <= err_overrun_d;

      if (byte_stb || !in_frame || timeout_hit) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + 16'd1;

      if (state_q == ST_LEN && byte_stb && len_good) begin
        len_q <= rx_data[AW:0];
        sum_q <= rx_data;
        idx_q <= '0;
      end else if (buf_we) begin
        sum_q <= sum_q + rx_data;
        idx_q <= idx_q + AW'(1);
      end

      if (load_frame) frame_len <= len_q;
    end
  end

  uart_frame_buf #(.AW(AW)) u_buf (
    .sys_clk (sys_clk),
    .we      (buf_we),
    .wr_addr (idx_q),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed vector table, corner sequences, random frames.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned TO      = 300;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          frame_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic [AW:0]   frame_len;
  logic          err_chk, err_len, err_timeout, err_overrun;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;

  always #5 sys_clk = ~sys_clk;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .AW(AW), .TIMEOUT_CLKS(TO)) dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  // Pulse counters: a stuck-high error output is counted once per cycle.
  always begin
    @(posedge sys_clk);
    #1;
    if (err_chk)     n_chk++;
    if (err_len)     n_len++;
    if (err_timeout) n_to++;
    if (err_overrun) n_ovr++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned         n;
    logic [23:0][7:0]    b;
    logic                exp_valid;
    int unsigned         exp_len;
    int unsigned         pay_off;
    int unsigned         exp_chk;
    int unsigned         exp_lenerr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    repeat (gap) @(negedge sys_clk);
    rx_valid = 1'b0;
    rx_data  = b;
    @(negedge sys_clk);
    rx_valid = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic do_ack(input logic with_byte, input logic [7:0] b);
    if (with_byte) begin
      rx_valid = 1'b0;
      rx_data  = b;
      @(negedge sys_clk);
      rx_valid = 1'b1;
    end
    frame_ack = 1'b1;
    @(negedge sys_clk);
    frame_ack = 1'b0;
    check("frame_valid_after_ack", 32'(frame_valid), 32'd0);
  endtask

  task automatic check_payload(input logic [7:0] pay[$]);
    foreach (pay[i]) begin
      @(negedge sys_clk);
      rd_addr = AW'(i);
      #1;
      check("rd_data", 32'(rd_data), 32'(pay[i]));
    end
  endtask

  task automatic run_frame(input logic [7:0] bytes[$], input int unsigned max_gap,
                           input logic exp_valid, input logic [7:0] exp_pay[$],
                           input int unsigned exp_chk, input int unsigned exp_lenerr);
    int unsigned c0, l0, t0;
    c0 = n_chk; l0 = n_len; t0 = n_to;
    foreach (bytes[i]) begin
      if (i == bytes.size() - 1) check("frame_valid_early", 32'(frame_valid), 32'd0);
      send_byte(bytes[i], $urandom_range(0, max_gap));
    end
    check("frame_valid", 32'(frame_valid), 32'(exp_valid));
    check("err_chk_count", n_chk - c0, exp_chk);
    check("err_len_count", n_len - l0, exp_lenerr);
    check("err_timeout_count", n_to - t0, 32'd0);
    if (exp_valid) begin
      check("frame_len", 32'(frame_len), 32'(exp_pay.size()));
      check_payload(exp_pay);
    end
  endtask

  function automatic logic [7:0] cksum(input logic [7:0] pay[$]);
    int unsigned s;
    s = pay.size();
    foreach (pay[i]) s += int'(pay[i]);
    return 8'(s % 256);
  endfunction

  function automatic void good_frame(input logic [7:0] pay[$], output logic [7:0] fr[$]);
    fr = {8'h55, 8'hAA, 8'(pay.size())};
    foreach (pay[i]) fr.push_back(pay[i]);
    fr.push_back(cksum(pay));
  endfunction

  vec_t vecs [9];

  initial begin
    logic [7:0] fr[$];
    logic [7:0] pay[$];
    logic [7:0] none[$];
    int unsigned o0, t0, first_to, to_seen;

    vecs[0] = '{7,  192'({8'h55,8'hAA,8'h03,8'h11,8'h22,8'h33,8'h69}), 1'b1, 3, 3, 0, 0};
    vecs[1] = '{6,  192'({8'h55,8'hAA,8'h02,8'hFF,8'hFF,8'h00}), 1'b1, 2, 3, 0, 0};
    vecs[2] = '{6,  192'({8'h55,8'hAA,8'h02,8'hFF,8'hFF,8'h01}), 1'b0, 0, 3, 1, 0};
    vecs[3] = '{3,  192'({8'h55,8'hAA,8'h00}), 1'b0, 0, 3, 0, 1};
    vecs[4] = '{3,  192'({8'h55,8'hAA,8'h11}), 1'b0, 0, 3, 0, 1};
    vecs[5] = '{20, 192'({8'h55,8'hAA,8'h10,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,
                          8'h08,8'h09,8'h0A,8'h0B,8'h0C,8'h0D,8'h0E,8'h0F,8'h88}), 1'b1, 16, 3, 0, 0};
    vecs[6] = '{6,  192'({8'h55,8'h55,8'hAA,8'h01,8'h7E,8'h7F}), 1'b1, 1, 4, 0, 0};
    vecs[7] = '{6,  192'({8'h12,8'h55,8'hAA,8'h01,8'h80,8'h81}), 1'b1, 1, 4, 0, 0};
    vecs[8] = '{5,  192'({8'h55,8'hAA,8'h01,8'h05,8'h00}), 1'b0, 0, 3, 1, 0};

    // Reset state
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset_frame_valid", 32'(frame_valid), 32'd0);
    check("reset_frame_len", 32'(frame_len), 32'd0);
    check("reset_err_any", 32'({err_chk, err_len, err_timeout, err_overrun}), 32'd0);

    // Directed vector table
    foreach (vecs[v]) begin
      fr.delete(); pay.delete();
      for (int unsigned i = 0; i < vecs[v].n; i++) fr.push_back(vecs[v].b[vecs[v].n - 1 - i]);
      for (int unsigned i = 0; i < vecs[v].exp_len; i++) pay.push_back(fr[vecs[v].pay_off + i]);
      run_frame(fr, 3, vecs[v].exp_valid, pay, vecs[v].exp_chk, vecs[v].exp_lenerr);
      if (vecs[v].exp_valid) do_ack(1'b0, 8'h00);
    end

    // Inter-byte timeout lands exactly TO cycles after the last strobe's update
    fr = {8'h55, 8'hAA, 8'h02, 8'h01};
    t0 = n_to;
    foreach (fr[i]) send_byte(fr[i], 0);
    first_to = 0; to_seen = 0;
    for (int unsigned j = 1; j <= TO + 5; j++) begin
      @(negedge sys_clk);
      if (err_timeout) begin
        to_seen++;
        if (first_to == 0) first_to = j;
      end
    end
    check("timeout_cycle", first_to, TO);
    check("timeout_pulses", n_to - t0, 32'd1);
    pay = {8'h7E};
    good_frame(pay, fr);
    run_frame(fr, 2, 1'b1, pay, 0, 0);
    do_ack(1'b0, 8'h00);

    // Strobe arriving in the would-be timeout cycle keeps the frame alive
    fr = {8'h55, 8'hAA, 8'h02, 8'h01};
    t0 = n_to;
    foreach (fr[i]) send_byte(fr[i], 0);
    send_byte(8'h02, TO - 2);
    send_byte(8'h05, 0);
    check("late_strobe_no_timeout", n_to - t0, 32'd0);
    check("late_strobe_frame_valid", 32'(frame_valid), 32'd1);
    check("late_strobe_frame_len", 32'(frame_len), 32'd2);
    do_ack(1'b0, 8'h00);

    // Overrun while holding, ack ignored outside HOLD, strobe in the ack cycle dropped
    frame_ack = 1'b1;
    send_byte(8'h55, 1);
    send_byte(8'hAA, 1);
    frame_ack = 1'b0;
    pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    fr = {8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h3C};
    foreach (fr[i]) send_byte(fr[i], 1);
    check("hold_frame_valid", 32'(frame_valid), 32'd1);
    o0 = n_ovr;
    send_byte(8'h55, 0);
    send_byte(8'hAA, 2);
    send_byte(8'h01, 1);
    check("overrun_pulses", n_ovr - o0, 32'd3);
    check("overrun_frame_len", 32'(frame_len), 32'd4);
    check("overrun_frame_valid", 32'(frame_valid), 32'd1);
    check_payload(pay);
    o0 = n_ovr;
    do_ack(1'b1, 8'h55);
    @(negedge sys_clk);
    check("ack_cycle_overrun", n_ovr - o0, 32'd1);
    fr = {8'hAA, 8'h01, 8'h7E, 8'h7F};
    run_frame(fr, 1, 1'b0, none, 0, 0);
    pay = {8'h33, 8'h44};
    good_frame(pay, fr);
    run_frame(fr, 1, 1'b1, pay, 0, 0);
    do_ack(1'b0, 8'h00);

    // Async reset mid-payload; rx_valid high coming out of reset is not a byte
    fr = {8'h55, 8'hAA, 8'h04, 8'h01, 8'h02};
    foreach (fr[i]) send_byte(fr[i], 0);
    #2 rst_n = 1'b0;
    rx_data = 8'h55;
    #1;
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    check("rst_err_any", 32'({err_chk, err_len, err_timeout, err_overrun}), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    fr = {8'hAA, 8'h01, 8'h7E, 8'h7F};
    run_frame(fr, 1, 1'b0, none, 0, 0);
    pay = {8'h10, 8'h20, 8'h30};
    good_frame(pay, fr);
    run_frame(fr, 1, 1'b1, pay, 0, 0);
    do_ack(1'b0, 8'h00);

    // Random frames against the frame-level reference model
    for (int k = 0; k < 40; k++) begin
      int unsigned kind, len, nov, noise;
      logic [7:0] b;
      kind  = $urandom_range(0, 9);
      noise = $urandom_range(0, 2);
      for (int unsigned i = 0; i < noise; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'h00;
        send_byte(b, $urandom_range(0, 4));
      end
      pay.delete();
      if (kind >= 8) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        fr = {8'h55, 8'hAA, 8'(len)};
        run_frame(fr, 10, 1'b0, none, 0, 1);
      end else begin
        len = $urandom_range(1, MAX_LEN);
        for (int unsigned i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
        good_frame(pay, fr);
        if (kind >= 6) begin
          fr[fr.size() - 1] = fr[fr.size() - 1] ^ 8'($urandom_range(1, 255));
          run_frame(fr, 10, 1'b0, none, 1, 0);
        end else begin
          run_frame(fr, 10, 1'b1, pay, 0, 0);
          nov = $urandom_range(0, 2);
          o0 = n_ovr;
          for (int unsigned i = 0; i < nov; i++) send_byte(8'($urandom_range(0, 255)), $urandom_range(0, 5));
          check("rand_overrun", n_ovr - o0, nov);
          check("rand_len_kept", 32'(frame_len), len);
          do_ack(1'b0, 8'h00);
        end
      end
    end

    repeat (5) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
